mac_simd_pipe: RTL and testbench

- Parameterised 3-stage signed multiply-accumulate unit with guard bits and saturation.
- Supports a runtime-selectable SIMD split mode: one W-bit lane, or SUB independent W/SUB-bit lanes sharing the same datapath.
- Adds an input-valid/output-valid handshake, global stall, and sticky per-lane overflow flags.
- Sits in the DSP datapath as the next-generation MAC engine, fed by the instruction issue stage.

---
 rtl/mac_simd_pipe.sv | 173 +++++++++++++++++
 tb/tb_mac_simd_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mac_simd_pipe.sv
// Three-stage signed multiply-accumulate engine with guard bits, saturation and a
// runtime SIMD split into SUB independent lanes that share one datapath.
module mac_simd_pipe #(
  parameter int W   = 16,
  parameter int G   = 8,
  parameter int SUB = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [2:0]       instruction,
  input  logic [W-1:0]     multiplicand,
  input  logic [W-1:0]     multiplier,
  output logic [2*W-1:0]   result,
  output logic [G-1:0]     protect,
  output logic             out_valid,
  output logic [SUB-1:0]   ovf
);

  localparam int LW = W / SUB;        // lane operand width
  localparam int LP = 2 * W / SUB;    // lane product / result width
  localparam int LG = G / SUB;        // lane guard width
  localparam int AW = 2 * W + G;      // full accumulator width
  localparam int LA = LP + LG;        // lane accumulator width

  typedef enum logic [1:0] {
    OP_CLR  = 2'b00,
    OP_LOAD = 2'b01,
    OP_ACC  = 2'b10,
    OP_SAT  = 2'b11
  } op_e;

  typedef struct packed {
    logic [AW-1:0] acc;
    logic          clamp;
  } full_res_t;

  typedef struct packed {
    logic [LA-1:0] acc;
    logic          clamp;
  } lane_res_t;

  // Stage registers
  logic          s1_valid, s1_split;
  op_e           s1_op;
  logic [W-1:0]  s1_a, s1_b;
  logic          s2_valid, s2_split;
  op_e           s2_op;
  logic [2*W-1:0] s2_pfull, s2_plane;

  logic [2*W-1:0] p_full, p_lane;
  logic [AW-1:0]  acc, acc_nxt;
  logic [SUB-1:0] ovf_nxt;

  assign acc = {protect, result};

  function automatic logic [LP-1:0] lane_ext(input logic [LW-1:0] v);
    return {{(LP-LW){v[LW-1]}}, v};
  endfunction

  // The value is out of range when the guard bits plus the result MSB disagree.
  function automatic full_res_t full_step(input op_e op, input logic [AW-1:0] a,
                                          input logic [2*W-1:0] p);
    full_res_t r;
    r.acc   = a;
    r.clamp = 1'b0;
    case (op)
      OP_CLR:  r.acc = '0;
      OP_LOAD: r.acc = {{G{p[2*W-1]}}, p};
      OP_ACC:  r.acc = a + {{G{p[2*W-1]}}, p};
      OP_SAT: begin
        if (!(&a[AW-1:2*W-1]) && (|a[AW-1:2*W-1])) begin
          r.acc[2*W-1:0] = a[AW-1] ? {1'b1, {(2*W-1){1'b0}}} : {1'b0, {(2*W-1){1'b1}}};
          r.clamp        = 1'b1;
        end
      end
      default: r.acc = a;
    endcase
    return r;
  endfunction

  function automatic lane_res_t lane_step(input op_e op, input logic [LA-1:0] a,
                                          input logic [LP-1:0] p);
    lane_res_t r;
    r.acc   = a;
    r.clamp = 1'b0;
    case (op)
      OP_CLR:  r.acc = '0;
      OP_LOAD: r.acc = {{LG{p[LP-1]}}, p};
      OP_ACC:  r.acc = a + {{LG{p[LP-1]}}, p};
      OP_SAT: begin
        if (!(&a[LA-1:LP-1]) && (|a[LA-1:LP-1])) begin
          r.acc[LP-1:0] = a[LA-1] ? {1'b1, {(LP-1){1'b0}}} : {1'b0, {(LP-1){1'b1}}};
          r.clamp       = 1'b1;
        end
      end
      default: r.acc = a;
    endcase
    return r;
  endfunction

  // Both product shapes are always formed; sign-extending first makes the
  // truncated unsigned product equal to the signed one.
  always_comb begin
    p_full = {{W{s1_a[W-1]}}, s1_a} * {{W{s1_b[W-1]}}, s1_b};
    p_lane = '0;
    for (int k = 0; k < SUB; k++) begin
      p_lane[k*LP +: LP] = lane_ext(s1_a[k*LW +: LW]) * lane_ext(s1_b[k*LW +: LW]);
    end
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    full_res_t fr;
    lane_res_t lr;
    acc_nxt = acc;
    ovf_nxt = ovf;
    fr      = '0;
    lr      = '0;
    if (s2_valid) begin
      if (!s2_split) begin
        fr      = full_step(s2_op, acc, s2_pfull);
        acc_nxt = fr.acc;
        if (fr.clamp) ovf_nxt[0] = 1'b1;
      end else begin
        for (int k = 0; k < SUB; k++) begin
          lr = lane_step(s2_op, {acc[2*W + k*LG +: LG], acc[k*LP +: LP]},
                         s2_plane[k*LP +: LP]);
          acc_nxt[k*LP +: LP]       = lr.acc[LP-1:0];
          acc_nxt[2*W + k*LG +: LG] = lr.acc[LA-1:LP];
          if (lr.clamp) ovf_nxt[k] = 1'b1;
        end
      end
      if (s2_op == OP_CLR) ovf_nxt = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages advance together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_split  <= 1'b0;
      s1_op     <= OP_CLR;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      s2_split  <= 1'b0;
      s2_op     <= OP_CLR;
      s2_pfull  <= '0;
      s2_plane  <= '0;
      result    <= '0;
      protect   <= '0;
      out_valid <= 1'b0;
      ovf       <= '0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s1_split  <= instruction[2];
      s1_op     <= op_e'(instruction[1:0]);
      s1_a      <= multiplicand;
      s1_b      <= multiplier;
      s2_valid  <= s1_valid;
      s2_split  <= s1_split;
      s2_op     <= s1_op;
      s2_pfull  <= p_full;
      s2_plane  <= p_lane;
      {protect, result} <= acc_nxt;
      out_valid <= s2_valid;
      ovf       <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_mac_simd_pipe.sv
// Directed scoreboard bench for mac_simd_pipe (W=16, G=8, SUB=2); expected
// responses are queued at issue time and popped by an independent monitor.
module tb_mac_simd_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        in_valid;
  logic [2:0]  instruction;
  logic [15:0] multiplicand, multiplier;
  logic [31:0] result;
  logic [7:0]  protect;
  logic        out_valid;
  logic [1:0]  ovf;

  mac_simd_pipe #(.W(16), .G(8), .SUB(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .in_valid     (in_valid),
    .instruction  (instruction),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .result       (result),
    .protect      (protect),
    .out_valid    (out_valid),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [7:0]  p;
    logic [1:0]  o;
    int          tag;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  int n_out = 0;
  logic adv = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Count only edges on which the pipeline actually advances.
  always @(posedge clk) begin
    adv <= !reset && !stall;
    if (!reset && !stall) edge_cnt <= edge_cnt + 1;
  end

  always @(negedge clk) begin
    if (!reset && adv && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out", out_valid, 1'b0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check($sformatf("result#%0d", n_out), result, e.r);
        check($sformatf("protect#%0d", n_out), protect, e.p);
        check($sformatf("ovf#%0d", n_out), ovf, e.o);
        check($sformatf("latency#%0d", n_out), edge_cnt - e.tag, 2);
        n_out++;
      end
    end
  end

  task automatic issue(input logic [2:0] ins, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] er, input logic [7:0] ep, input logic [1:0] eo);
    exp_t e;
    in_valid     = 1'b1;
    instruction  = ins;
    multiplicand = a;
    multiplier   = b;
    @(posedge clk);
    #1;
    e.r = er; e.p = ep; e.o = eo; e.tag = edge_cnt;
    q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    stall        = 1'b0;
    in_valid     = 1'b0;
    instruction  = 3'b000;
    multiplicand = '0;
    multiplier   = '0;
    @(posedge clk);
    #1;
    check("rst_result", result, 0);
    check("rst_protect", protect, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b0;

    // Full-mode load, then bubble must drop out_valid.
    issue(3'b001, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 8'h00, 2'b00);
    idle(3);
    check("bubble_valid", out_valid, 0);
    check("bubble_hold", result, 32'h3FFF0001);

    // Full mode positive overflow and clamp.
    issue(3'b001, 16'h8000, 16'h8000, 32'h40000000, 8'h00, 2'b00);
    issue(3'b010, 16'h8000, 16'h8000, 32'h80000000, 8'h00, 2'b00);
    issue(3'b010, 16'h8000, 16'h8000, 32'hC0000000, 8'h00, 2'b00);
    issue(3'b011, 16'h0000, 16'h0000, 32'h7FFFFFFF, 8'h00, 2'b01);
    issue(3'b000, 16'h0000, 16'h0000, 32'h00000000, 8'h00, 2'b00);

    // Full mode negative overflow and clamp, guard bits stay all ones.
    issue(3'b001, 16'h8000, 16'h7FFF, 32'hC0008000, 8'hFF, 2'b00);
    issue(3'b010, 16'h8000, 16'h7FFF, 32'h80010000, 8'hFF, 2'b00);
    issue(3'b010, 16'h8000, 16'h7FFF, 32'h40018000, 8'hFF, 2'b00);
    issue(3'b011, 16'h0000, 16'h0000, 32'h80000000, 8'hFF, 2'b01);
    issue(3'b000, 16'h0000, 16'h0000, 32'h00000000, 8'h00, 2'b00);

    // Split mode: independent lane products.
    issue(3'b101, 16'h7F80, 16'h7F80, 32'h3F014000, 8'h00, 2'b00);

    // Split mode: lane 0 overflows and clamps, lane 1 untouched.
    issue(3'b101, 16'h0080, 16'h0080, 32'h00004000, 8'h00, 2'b00);
    issue(3'b110, 16'h0080, 16'h0080, 32'h00008000, 8'h00, 2'b00);
    issue(3'b111, 16'h0000, 16'h0000, 32'h00007FFF, 8'h00, 2'b01);
    issue(3'b100, 16'h0000, 16'h0000, 32'h00000000, 8'h00, 2'b00);

    // Split mode: lane 1 negative overflow, clamps to 0x8000 with ovf[1].
    issue(3'b101, 16'h8000, 16'h7F00, 32'hC0800000, 8'hF0, 2'b00);
    issue(3'b110, 16'h8000, 16'h7F00, 32'h81000000, 8'hF0, 2'b00);
    issue(3'b110, 16'h8000, 16'h7F00, 32'h41800000, 8'hF0, 2'b00);
    issue(3'b111, 16'h0000, 16'h0000, 32'h80000000, 8'hF0, 2'b10);

    // Async reset with an accumulate in flight; that op must be lost.
    issue(3'b001, 16'h0002, 16'h0005, 32'h0000000A, 8'h00, 2'b10);
    issue(3'b010, 16'h0002, 16'h0005, 32'h00000014, 8'h00, 2'b10);
    @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_result", result, 0);
    check("arst_protect", protect, 0);
    check("arst_valid", out_valid, 0);
    check("arst_ovf", ovf, 0);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(4);
    issue(3'b001, 16'h0003, 16'h0004, 32'h0000000C, 8'h00, 2'b00);

    // Stall: outputs frozen, inputs during stall ignored, result two edges later.
    issue(3'b000, 16'h0000, 16'h0000, 32'h00000000, 8'h00, 2'b00);
    idle(3);
    issue(3'b001, 16'h0002, 16'h0003, 32'h00000006, 8'h00, 2'b00);
    stall        = 1'b1;
    in_valid     = 1'b1;
    instruction  = 3'b001;
    multiplicand = 16'h7FFF;
    multiplier   = 16'h7FFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall_valid%0d", i), out_valid, 0);
      check($sformatf("stall_result%0d", i), result, 0);
    end
    stall    = 1'b0;
    in_valid = 1'b0;
    idle(4);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    check("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
